// File: rtl/inst_rom_loader.sv
// Instruction store served to the core's fetch port, rewritten by a byte-serial loader.
// Optional macro INST_ROM_CLEAR_EN zero-fills the whole store before each load.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [ADDR_W-1:0]     rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_hold_o,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic [DEPTH_LOG2:0]   ld_count_o,
  output logic                  ld_done_o,
  output logic                  ld_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {RUN = 2'd0, CLEAR = 2'd1, LOAD = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  err_q, err_d;
  logic [31:0]           mem [DEPTH];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic                  acc;
  logic                  word_done;
  logic [31:0]           word;
  logic                  unused_addr_lsb;
`ifdef INST_ROM_CLEAR_EN
  logic [DEPTH_LOG2-1:0] clr_q, clr_d;
`endif

  // A start pulse in LOAD takes priority over a byte presented in the same cycle.
  assign acc       = (state_q == LOAD) && !ld_start_i && ld_valid_i;
  assign word      = {asm_q, 8'h00} | ({ld_byte_i, 24'h000000} >> {bcnt_q, 3'b000});
  assign word_done = acc && ((bcnt_q == 2'd3) || ld_last_i);
  assign unused_addr_lsb = ^rom_addr_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
`ifdef INST_ROM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
`ifdef INST_ROM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (ld_start_i) begin
`ifdef INST_ROM_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef INST_ROM_CLEAR_EN
      CLEAR: if (clr_q == '1) state_d = LOAD;
`endif
      LOAD:    if (acc && ld_last_i) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Pointer saturates at DEPTH: further completed words only raise the sticky error.
  always_comb begin
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q[DEPTH_LOG2-1:0];
    mem_wdata = word;
`ifdef INST_ROM_CLEAR_EN
    clr_d     = clr_q;
`endif
    if (ld_start_i && ((state_q == RUN) || (state_q == LOAD))) begin
      ptr_d  = '0;
      bcnt_d = '0;
      asm_d  = '0;
      err_d  = 1'b0;
`ifdef INST_ROM_CLEAR_EN
      clr_d  = '0;
`endif
    end else if (acc) begin
      if (word_done) begin
        bcnt_d = '0;
        asm_d  = '0;
        if (ptr_q[DEPTH_LOG2]) begin
          err_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + CW'(1);
        end
      end else begin
        bcnt_d = bcnt_q + 2'd1;
        asm_d  = word[31:8];
      end
    end
`ifdef INST_ROM_CLEAR_EN
    else if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_q;
      mem_wdata = 32'h0;
      clr_d     = clr_q + DEPTH_LOG2'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch returns NOP unless running, enabled and inside the store.
  always_comb begin
    cpu_hold_o = (state_q != RUN);
    ld_ready_o = (state_q == LOAD);
    ld_done_o  = (state_q == DONE);
    rom_data_o = 32'h0;
    if ((state_q == RUN) && rom_ce_i && (rom_addr_i[ADDR_W-1:DEPTH_LOG2+2] == '0))
      rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]];
  end

  assign ld_count_o = ptr_q;
  assign ld_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed/randomized bench for inst_rom_loader against a byte-queue reference model.
// Honors INST_ROM_CLEAR_EN the same way as the design.
module tb_inst_rom_loader;

`ifdef INST_ROM_CLEAR_EN
  localparam int CLR_CYC = 1024;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        hold;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ready, done, err;
  logic [10:0] count;

  int          vecs = 0;
  int          miss = 0;
  bit [7:0]    q[$];
  bit [7:0]    stim[$];
  logic [31:0] mmem[1024];
  bit          known[1024];
  int          exp_cnt;
  bit          exp_err;
  logic [31:0] old1, old2, w0;

  inst_rom_loader #(.DEPTH_LOG2(10), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
    .cpu_hold_o(hold),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ready), .ld_count_o(count), .ld_done_o(done), .ld_err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a finished load packs its bytes big-endian into zero-padded words.
  task automatic commit();
    int nw;
    logic [31:0] wv;
    nw = (q.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      wv = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < q.size()) wv = wv | (32'(q[4*w+k]) << (24 - 8*k));
      if (w < 1024) begin
        mmem[w]  = wv;
        known[w] = 1'b1;
      end
    end
    exp_cnt = (nw > 1024) ? 1024 : nw;
    exp_err = (nw > 1024);
  endtask

  task automatic fetch(input string tag, input logic ce, input logic [31:0] a, input logic [31:0] exp);
    rom_ce   = ce;
    rom_addr = a;
    @(negedge clk);
    check(tag, rom_data, exp);
    rom_ce = 1'b0;
    tick();
  endtask

  task automatic check_mem();
    for (int w = 0; w < 1024; w++)
      if (known[w]) fetch("mem_word", 1'b1, 32'(w * 4 + $urandom_range(0, 3)), mmem[w]);
  endtask

  task automatic start_pulse();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    q.delete();
`ifdef INST_ROM_CLEAR_EN
    for (int w = 0; w < 1024; w++) begin
      mmem[w]  = 32'h0;
      known[w] = 1'b1;
    end
`endif
    check("hold_after_start", hold, 1);
    check("err_after_start", err, 0);
    check("count_after_start", count, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 5000) begin
      tick();
      n++;
    end
    check("cycles_before_ready", n, CLR_CYC);
    check("hold_in_load", hold, 1);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit last);
    if ($urandom_range(0, 3) == 0) begin
      ld_valid = 1'b0;
      tick();
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    q.push_back(b);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_byte  = 8'($urandom);
  endtask

  task automatic end_load();
    commit();
    check("done_pulse", done, 1);
    check("hold_in_done", hold, 1);
    check("ready_in_done", ready, 0);
    check("count_at_done", count, exp_cnt);
    check("err_at_done", err, exp_err);
    tick();
    check("done_low_in_run", done, 0);
    check("hold_low_in_run", hold, 0);
    check("count_in_run", count, exp_cnt);
    check("err_in_run", err, exp_err);
  endtask

  task automatic run_load();
    start_pulse();
    wait_ready();
    foreach (stim[i]) send_byte(stim[i], i == stim.size() - 1);
    end_load();
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b0; rom_ce = 1'b0; rom_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    for (int w = 0; w < 1024; w++) known[w] = 1'b0;
    repeat (3) tick();
    check("rst_hold", hold, 0);
    check("rst_ready", ready, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();

    // Single directed word.
    stim = {8'h20, 8'h01, 8'h00, 8'h05};
    run_load();
    check("count_one_word", count, 1);
    fetch("fetch_addr0", 1'b1, 32'h0, 32'h20010005);
    fetch("fetch_addr3", 1'b1, 32'h3, 32'h20010005);
    fetch("fetch_ce0", 1'b0, 32'h0, 32'h0);
    fetch("fetch_oob", 1'b1, 32'h0000_1000, 32'h0);

    // Partial final word is zero-padded.
    stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_load();
    check("count_two_words", count, 2);
    fetch("word0_aabbccdd", 1'b1, 32'h0, 32'hAABBCCDD);
    fetch("word1_padded", 1'b1, 32'h4, 32'h11220000);

    // Preload 3 words, then a 1-word program.
    rand_stim(12);
    run_load();
    old1 = mmem[1];
    old2 = mmem[2];
    rand_stim(4);
    run_load();
`ifdef INST_ROM_CLEAR_EN
    fetch("word1_after_short", 1'b1, 32'h4, 32'h0);
    fetch("word2_after_short", 1'b1, 32'h8, 32'h0);
`else
    fetch("word1_after_short", 1'b1, 32'h4, old1);
    fetch("word2_after_short", 1'b1, 32'h8, old2);
`endif
    check_mem();

    // Restart in the middle of a load discards the partial word.
    start_pulse();
    wait_ready();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    rom_ce = 1'b1; rom_addr = 32'h0;
    #1;
    check("fetch_gated_in_load", rom_data, 0);
    rom_ce = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    q.delete();
    check("restart_count", count, 0);
    check("restart_ready", ready, 1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
    end_load();
    check_mem();

    // Reset after 2 of 4 bytes, then a full load.
    start_pulse();
    wait_ready();
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_hold", hold, 0);
    check("midrst_ready", ready, 0);
    check("midrst_count", count, 0);
    check("midrst_done", done, 0);
    tick();
    rst = 1'b1;
    q.delete();
    tick();
    rand_stim(8);
    run_load();
    check_mem();

    // Overflow: 4100 bytes into 1024 words.
    rand_stim(4100);
    w0 = {stim[0], stim[1], stim[2], stim[3]};
    run_load();
    check("overflow_count", count, 1024);
    check("overflow_err", err, 1);
    fetch("overflow_word0", 1'b1, 32'h0, w0);
    check_mem();
    rand_stim(4);
    run_load();
    check_mem();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Responder end of the core's instruction-fetch interface (`rom_ce`/`rom_addr`/`rom_data`). It serves 32-bit words from an on-chip instruction store. A byte-serial loader writes new programs into that store and holds the core off the fetch port while loading. It sits beside the `PipeLine` top and connects directly to `rom_ce_o`, `rom_addr_o` and `rom_data_i`.

## Interface
- `DEPTH_LOG2`, 10, log2 of store depth in 32-bit words (1024 words).
- `ADDR_W`, 32, width of the fetch byte address.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rom_ce_i` input 1: fetch enable from the core.
- `rom_addr_i` input ADDR_W: fetch byte address; bits [1:0] ignored.
- `rom_data_o` output 32: fetched instruction word.
- `cpu_hold_o` output 1: high while the store is being rewritten; the integration ties this into the core's reset.
- `ld_start_i` input 1: one-cycle pulse that begins a program load.
- `ld_valid_i` input 1: a load byte is presented this cycle.
- `ld_byte_i` input 8: load data byte.
- `ld_last_i` input 1: qualifies the final byte of the program.
- `ld_ready_o` output 1: the loader accepts a byte this cycle.
- `ld_count_o` output DEPTH_LOG2+1: number of words written by the current or last load.
- `ld_done_o` output 1: one-cycle pulse when a load completes.
- `ld_err_o` output 1: sticky overflow flag, cleared by the next `ld_start_i`.

## Operation
- States: RUN, CLEAR (only with the macro), LOAD, DONE. Reset enters RUN.
- Reset values: `cpu_hold_o`=0, `ld_ready_o`=0, `ld_count_o`=0, `ld_done_o`=0, `ld_err_o`=0. Byte counter, word pointer and assembly register are all 0. Store contents are not reset.
- RUN:
  - `rom_data_o` = `mem[rom_addr_i[DEPTH_LOG2+1:2]]` when `rom_ce_i`=1 and `rom_addr_i[ADDR_W-1:DEPTH_LOG2+2]`=0.
  - Otherwise `rom_data_o` = 32'h0 (NOP).
  - On `ld_start_i`: go to CLEAR if the macro is defined, else LOAD. Clear pointer, count and error.
- LOAD:
  - `cpu_hold_o`=1, `ld_ready_o`=1, `rom_data_o`=0.
  - A byte is accepted when `ld_valid_i` and `ld_ready_o` are both high.
  - Bytes are big-endian: the first byte of each word goes to bits [31:24].
  - On the 4th byte of a word: write the word at the pointer, increment the pointer and `ld_count_o`.
  - If `ld_last_i` arrives with a partial word, zero-pad the remaining low bytes and write it.
  - If the pointer equals 2^DEPTH_LOG2 when a word completes: discard the write, set `ld_err_o`, leave the count unchanged, keep accepting bytes until `ld_last_i`.
  - A byte with `ld_last_i` moves the FSM to DONE.
  - `ld_start_i` during LOAD restarts the load: pointer, count, byte counter and error cleared; the partial word is discarded.
  - `ld_valid_i` while not in LOAD is ignored.
- DONE: lasts one cycle. `ld_done_o`=1, `cpu_hold_o`=1, `ld_ready_o`=0. Then go to RUN.
- Reset mid-load: returns to RUN immediately, hold released. Store contents written so far are kept.

## Timing
- Fetch is combinational (zero latency). The core's IF_ID register captures `rom_data_o` on the same edge the PC presents.
- A store write in LOAD is visible to fetch from the next cycle; fetch is gated off until RUN anyway.
- `cpu_hold_o` rises in the cycle after `ld_start_i` and falls in the cycle after DONE.
- Minimum load of an N-byte program: 1 + N + 1 cycles, plus 2^DEPTH_LOG2 cycles if CLEAR is compiled in.

## Configuration
- `INST_ROM_CLEAR_EN` defined:
  - `ld_start_i` enters CLEAR, which writes 0 to every word, one per cycle, for 2^DEPTH_LOG2 cycles.
  - During CLEAR, `cpu_hold_o`=1 and `ld_ready_o`=0. The FSM then moves to LOAD.
  - Words beyond the new program read as 0.
- Not defined: no CLEAR state; words beyond the new program keep their old contents.

## Test plan
- Reset, then load bytes 20,01,00,05 with last on the 4th byte. Expect: `ld_count_o`=1, a `ld_done_o` pulse, and fetch with ce=1 at addr 0x0 returns 32'h20010005.
- Fetch with ce=0 or addr 0x0000_1000 (beyond 1024 words) -> `rom_data_o`=0; addr 0x3 returns the same word as addr 0x0.
- Load 6 bytes AA,BB,CC,DD,11,22 with last on the 6th byte. Expect count=2, word0=AABBCCDD, word1=11220000.
- Load 4100 bytes into a 1024-word store. Expect count=1024, `ld_err_o`=1, and word 0 holds the first four bytes. A subsequent `ld_start_i` clears `ld_err_o`.
- Deassert `rst` after 2 of 4 bytes. Expect state RUN, hold=0, ready=0, count=0; a restarted full load then succeeds.
- With `INST_ROM_CLEAR_EN`: preload 3 words, then load 1 word. Expect words 1-2 read 0 and hold stays high for 1024 cycles before ready rises. Without the macro, words 1-2 keep their old values.
